// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard/flush controller (slave).
interface pipe_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_rq_addr;
    logic [3:0]  id_rs_addr;
    logic [3:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic        ex_is_load;
    logic        ex_multi;
    logic [3:0]  ex_multi_cycles;
    logic        ex_flush;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        hold_ex;
    logic        flush_ifid;
    logic [1:0]  state;
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;

    modport master (
        output id_valid, id_rq_addr, id_rs_addr, ex_rd_addr, ex_rd_we, ex_is_load,
               ex_multi, ex_multi_cycles, ex_flush,
        input  stall_if, stall_id, bubble_ex, hold_ex, flush_ifid, state,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_valid, id_rq_addr, id_rs_addr, ex_rd_addr, ex_rd_we, ex_is_load,
               ex_multi, ex_multi_cycles, ex_flush,
        output stall_if, stall_id, bubble_ex, hold_ex, flush_ifid, state,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, multi-cycle EX holds, branch flushes.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, MULTI = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [3:0] FLUSH_INIT = (FLUSH_DEPTH > 1) ? 4'(FLUSH_DEPTH - 2) : 4'd0;

    state_t     st, st_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hazard;
    logic       c_stall, c_bubble, c_hold, c_flush;

    assign hazard = bus.id_valid & bus.ex_is_load & bus.ex_rd_we & (bus.ex_rd_addr != 4'd0) &
                    ((bus.ex_rd_addr == bus.id_rq_addr) | (bus.ex_rd_addr == bus.id_rs_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= RUN;
            cnt <= 4'd0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        c_stall  = 1'b0;
        c_bubble = 1'b0;
        c_hold   = 1'b0;
        c_flush  = 1'b0;
        case (st)
            RUN: begin
                // An asserted ex_multi outranks the hazard even when N=0, so it then does nothing.
                if (bus.ex_flush) begin
                    c_flush = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        st_nxt  = FLUSH;
                        cnt_nxt = FLUSH_INIT;
                    end
                end else if (bus.ex_multi) begin
                    if (bus.ex_multi_cycles != 4'd0) begin
                        c_stall = 1'b1;
                        c_hold  = 1'b1;
                        st_nxt  = MULTI;
                        cnt_nxt = bus.ex_multi_cycles - 4'd1;
                    end
                end else if (hazard) begin
                    c_stall  = 1'b1;
                    c_bubble = 1'b1;
                end
            end
            MULTI: begin
                c_stall = 1'b1;
                c_hold  = 1'b1;
                if (cnt == 4'd0) st_nxt = RUN;
                else             cnt_nxt = cnt - 4'd1;
            end
            FLUSH: begin
                c_flush = 1'b1;
                if (cnt == 4'd0) st_nxt = RUN;
                else             cnt_nxt = cnt - 4'd1;
            end
            default: begin
                st_nxt  = RUN;
                cnt_nxt = 4'd0;
            end
        endcase
    end

    // Outputs are masked while reset is held so stray inputs cannot leak through.
    assign bus.stall_if   = c_stall  & ~rst;
    assign bus.stall_id   = c_stall  & ~rst;
    assign bus.bubble_ex  = c_bubble & ~rst;
    assign bus.hold_ex    = c_hold   & ~rst;
    assign bus.flush_ifid = c_flush  & ~rst;
    assign bus.state      = st;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (c_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (c_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`else
    assign bus.perf_stall_cnt = 16'd0;
    assign bus.perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: two instances (FLUSH_DEPTH 2 and 1) against a cycle-count model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       id_valid, ex_rd_we, ex_is_load, ex_multi, ex_flush;
    logic [3:0] id_rq_addr, id_rs_addr, ex_rd_addr, ex_multi_cycles;

    pipe_ctrl_if bus0();
    pipe_ctrl_if bus1();

    assign bus0.id_valid = id_valid;        assign bus1.id_valid = id_valid;
    assign bus0.id_rq_addr = id_rq_addr;    assign bus1.id_rq_addr = id_rq_addr;
    assign bus0.id_rs_addr = id_rs_addr;    assign bus1.id_rs_addr = id_rs_addr;
    assign bus0.ex_rd_addr = ex_rd_addr;    assign bus1.ex_rd_addr = ex_rd_addr;
    assign bus0.ex_rd_we = ex_rd_we;        assign bus1.ex_rd_we = ex_rd_we;
    assign bus0.ex_is_load = ex_is_load;    assign bus1.ex_is_load = ex_is_load;
    assign bus0.ex_multi = ex_multi;        assign bus1.ex_multi = ex_multi;
    assign bus0.ex_multi_cycles = ex_multi_cycles;
    assign bus1.ex_multi_cycles = ex_multi_cycles;
    assign bus0.ex_flush = ex_flush;        assign bus1.ex_flush = ex_flush;

    pipe_ctrl #(.FLUSH_DEPTH(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipe_ctrl #(.FLUSH_DEPTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: remaining busy cycles per instance, derived from the N+1 stall / FLUSH_DEPTH flush rules.
    int depth[2] = '{2, 1};
    int multi_left[2], flush_left[2], pstall[2], pflush[2];

    function automatic logic hazard_now();
        return id_valid && ex_is_load && ex_rd_we && ex_rd_addr != 0 &&
               (ex_rd_addr == id_rq_addr || ex_rd_addr == id_rs_addr);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            multi_left[d] = 0; flush_left[d] = 0; pstall[d] = 0; pflush[d] = 0;
        end
    endtask

    // Bit order: {stall_if, stall_id, bubble_ex, hold_ex, flush_ifid, state[1:0]}
    task automatic model_step(input int d, output logic [6:0] e);
        e = 7'b0;
        if (rst) begin
            model_reset();
        end else if (multi_left[d] > 0) begin
            e = 7'b1101_0_01; multi_left[d]--;
        end else if (flush_left[d] > 0) begin
            e = 7'b0000_1_10; flush_left[d]--;
        end else if (ex_flush) begin
            e = 7'b0000_1_00; flush_left[d] = depth[d] - 1;
        end else if (ex_multi) begin
            if (ex_multi_cycles != 0) begin
                e = 7'b1101_0_00; multi_left[d] = int'(ex_multi_cycles);
            end
        end else if (hazard_now()) begin
            e = 7'b1110_0_00;
        end
        if (e[6] && pstall[d] < 65535) pstall[d]++;
        if (e[2] && pflush[d] < 65535) pflush[d]++;
    endtask

    function automatic int perf_exp(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Entered at posedge+1 with inputs already driven; checks mid-cycle, returns at next posedge+1.
    task automatic tick(input string tag);
        logic [6:0] e0, e1;
        #4;
        chk({tag, ":perf_stall0"}, 32'(bus0.perf_stall_cnt), 32'(perf_exp(pstall[0])));
        chk({tag, ":perf_flush0"}, 32'(bus0.perf_flush_cnt), 32'(perf_exp(pflush[0])));
        chk({tag, ":perf_flush1"}, 32'(bus1.perf_flush_cnt), 32'(perf_exp(pflush[1])));
        model_step(0, e0);
        model_step(1, e1);
        chk({tag, ":out_d2"}, 32'({bus0.stall_if, bus0.stall_id, bus0.bubble_ex, bus0.hold_ex,
                                   bus0.flush_ifid, bus0.state}), 32'(e0));
        chk({tag, ":out_d1"}, 32'({bus1.stall_if, bus1.stall_id, bus1.bubble_ex, bus1.hold_ex,
                                   bus1.flush_ifid, bus1.state}), 32'(e1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rq_addr = 0; id_rs_addr = 0; ex_rd_addr = 0; ex_rd_we = 0;
        ex_is_load = 0; ex_multi = 0; ex_multi_cycles = 0; ex_flush = 0;
    endtask

    task automatic load_use(input logic [3:0] rd, input logic [3:0] rs);
        idle();
        id_valid = 1; id_rs_addr = rs; id_rq_addr = 4'd9;
        ex_rd_addr = rd; ex_rd_we = 1; ex_is_load = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        @(posedge clk); #1;
        // Hazard inputs during reset must stay invisible.
        load_use(4'd5, 4'd5);
        tick("in_reset");
        idle();
        rst = 0;
        tick("after_reset");

        load_use(4'd5, 4'd5);  tick("load_use");
        idle();                tick("load_use_end");
        load_use(4'd0, 4'd0);  tick("load_r0");
        load_use(4'd7, 4'd7);
        id_rs_addr = 4'd2; id_rq_addr = 4'd7;
        tick("load_rq");

        idle(); ex_multi = 1; ex_multi_cycles = 4'd3;
        tick("multi3_trig");
        idle();
        for (int i = 0; i < 4; i++) tick("multi3");
        ex_multi = 1; ex_multi_cycles = 4'd0;
        tick("multi0");

        idle(); ex_flush = 1; tick("flush_trig");
        idle();
        for (int i = 0; i < 2; i++) tick("flush");

        load_use(4'd3, 4'd3); ex_flush = 1; ex_multi = 1; ex_multi_cycles = 4'd2;
        tick("all_three");
        idle();
        for (int i = 0; i < 2; i++) tick("all_three_tail");

        // Asynchronous reset in MULTI with cnt=2: outputs must clear before the next edge.
        ex_multi = 1; ex_multi_cycles = 4'd4;
        tick("mid_multi_trig");
        idle();
        tick("mid_multi_1");
        #1 rst = 1;
        #1;
        chk("async_rst_state", 32'(bus0.state), 32'd0);
        chk("async_rst_ctrl", 32'({bus0.stall_if, bus0.stall_id, bus0.hold_ex, bus1.stall_if}), 32'd0);
        chk("async_rst_perf", 32'(bus0.perf_stall_cnt), 32'd0);
        model_reset();
        #1 rst = 0;
        @(posedge clk); #1;
        tick("post_async_rst");

        // Perf scenario: one 3-cycle multi op plus one flush.
        ex_multi = 1; ex_multi_cycles = 4'd3; tick("perf_multi");
        idle();
        for (int i = 0; i < 3; i++) tick("perf_multi_tail");
        ex_flush = 1; tick("perf_flush");
        idle(); tick("perf_flush_tail");
        tick("perf_idle");
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_total", 32'(bus0.perf_stall_cnt), 32'd4 + 32'(pstall[0]) - 32'd4);
        chk("perf_flush_total", 32'(bus0.perf_flush_cnt), 32'd2);
`else
        chk("perf_stall_off", 32'(bus0.perf_stall_cnt), 32'd0);
        chk("perf_flush_off", 32'(bus0.perf_flush_cnt), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rq_addr      = 4'($urandom_range(0, 3));
            id_rs_addr      = 4'($urandom_range(0, 3));
            ex_rd_addr      = 4'($urandom_range(0, 3));
            ex_rd_we        = ($urandom_range(0, 3) != 0);
            ex_is_load      = ($urandom_range(0, 1) != 0);
            ex_multi        = ($urandom_range(0, 7) == 0);
            ex_multi_cycles = 4'($urandom_range(0, 5));
            ex_flush        = ($urandom_range(0, 7) == 0);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of consecutive cycles flush_ifid is asserted per taken branch (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid  input  1  decode stage holds a valid instruction.
REQ-005 SHALL have ports id_rq_addr, id_rs_addr  input  4 each  source register addresses of the decode instruction.
REQ-006 SHALL have ports ex_rd_addr  input  4, ex_rd_we  input  1, ex_is_load  input  1  destination, write enable and load flag of the execute instruction.
REQ-007 SHALL have ports ex_multi  input  1, ex_multi_cycles  input  4  execute instruction is multi-cycle; extra cycles it needs.
REQ-008 SHALL have port ex_flush  input  1  taken branch/jump resolved in execute.
REQ-009 SHALL have ports stall_if, stall_id  output  1 each  hold PC / hold IF-ID register.
REQ-010 SHALL have ports bubble_ex  output  1, hold_ex  output  1, flush_ifid  output  1  insert NOP into ID-EX / hold ID-EX / kill IF-ID contents.
REQ-011 SHALL have port state  output  2  RUN=0, MULTI=1, FLUSH=2.
REQ-012 SHALL have ports perf_stall_cnt, perf_flush_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-013 SHALL implement an FSM with states RUN, MULTI, FLUSH and a 4-bit down-counter cnt.
REQ-014 In RUN, event priority SHALL be ex_flush > ex_multi > load-use hazard; only the highest-priority event acts.
REQ-015 Load-use hazard SHALL be: id_valid & ex_is_load & ex_rd_we & ex_rd_addr!=0 & (ex_rd_addr==id_rq_addr | ex_rd_addr==id_rs_addr).
REQ-016 On load-use in RUN, stall_if, stall_id, bubble_ex SHALL be 1 combinationally that cycle; state stays RUN (single-cycle stall).
REQ-017 On ex_flush in RUN, flush_ifid SHALL be 1 that cycle; if FLUSH_DEPTH>1 next state FLUSH with cnt=FLUSH_DEPTH-2, else stay RUN.
REQ-018 In FLUSH, flush_ifid SHALL be 1; cnt decrements each cycle; when cnt==0 next state RUN; ex_flush, ex_multi and hazards ignored.
REQ-019 On ex_multi with ex_multi_cycles=N>0 in RUN, stall_if, stall_id, hold_ex SHALL be 1 that cycle; next state MULTI with cnt=N-1.
REQ-020 ex_multi with N=0 SHALL cause no stall and no state change.
REQ-021 In MULTI, stall_if, stall_id, hold_ex SHALL be 1; cnt decrements; when cnt==0 next state RUN; all other inputs ignored.
REQ-022 Total stall for a multi-cycle op SHALL be exactly N+1 cycles (trigger cycle plus N in MULTI... first cycle is the trigger).
REQ-023 hold_ex and bubble_ex SHALL never be 1 in the same cycle; flush_ifid and stall_if SHALL never be 1 in the same cycle.
REQ-024 All control outputs SHALL be 0 in RUN when no event is present.

Reset
REQ-025 Asserting rst SHALL immediately force state=RUN, cnt=0, perf counters=0, regardless of clk, including mid-MULTI or mid-FLUSH.
REQ-026 During and after reset, before any event, all control outputs SHALL be 0.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN defined: perf_stall_cnt SHALL increment every cycle stall_if=1, perf_flush_cnt every cycle flush_ifid=1; both saturate at 16'hFFFF.
REQ-028 Macro PIPE_CTRL_PERF_EN undefined: both perf outputs SHALL be constant 0 and no counter registers exist.

Verification
REQ-029 Load in EX writing r5, decode reads r5 on id_rs_addr -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; r0 destination -> no stall.
REQ-030 ex_multi=1, ex_multi_cycles=3 -> stall_if/hold_ex high 4 cycles, state 1 for 3 cycles, then 0.
REQ-031 ex_flush pulse with FLUSH_DEPTH=2 -> flush_ifid high 2 cycles; FLUSH_DEPTH=1 -> 1 cycle, state stays 0.
REQ-032 ex_flush, ex_multi and load-use simultaneous in RUN -> only flush_ifid asserted, no stall.
REQ-033 rst asserted mid-MULTI (cnt=2) asynchronously -> state=0, all outputs 0 before next clk edge.
REQ-034 With PIPE_CTRL_PERF_EN, one 3-cycle multi op plus one flush (FLUSH_DEPTH=2) -> perf_stall_cnt=4, perf_flush_cnt=2; without macro both 0.
